// File: rtl/mcycle_unit_pkg.sv
// Shared op and state encodings for the multi-cycle multiply/divide unit.
// No logic; constants and types only.
// No flow control.
package mcycle_unit_pkg;

  localparam logic MCYCLE_MUL = 1'b0;
  localparam logic MCYCLE_DIV = 1'b1;

  typedef enum logic [1:0] {
    MC_IDLE    = 2'd0,
    MC_COMPUTE = 2'd1,
    MC_DONE    = 2'd2
  } mc_state_e;

endpackage

// File: rtl/mcycle_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Combinational, zero latency.
// No flow control; the parent decides when to register acc_next.
module mcycle_step
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  always_comb begin
    // MUL: acc = {product_hi, multiplier}; the carry of the add shifts back in.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // DIV: acc = {rem, dividend/quotient}; compare needs the bit shifted out of rem.
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;

    if (op == MCYCLE_MUL) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned MUL/DIV beside the ALU; one iteration per clock.
// Busy for WIDTH+1 cycles from the Start cycle; results registered and held.
// Busy stalls the pipeline; Start is ignored outside IDLE.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mc_state_e          state;
  logic [CW-1:0]      count;
  logic               op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;

  mcycle_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_next)
  );

  // Stall must begin in the request cycle itself, hence combinational in IDLE.
  always_comb begin
    Busy = 1'b0;
    case (state)
      MC_IDLE:    Busy = Start;
      MC_COMPUTE: Busy = 1'b1;
      default:    Busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= MC_IDLE;
      count   <= '0;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (Start) begin
            op_q   <= MCycleOp;
            opnd_q <= (MCycleOp == MCYCLE_MUL) ? Operand1 : Operand2;
            acc_q  <= {{WIDTH{1'b0}}, ((MCycleOp == MCYCLE_MUL) ? Operand2 : Operand1)};
            count  <= '0;
            state  <= MC_COMPUTE;
          end
        end
        MC_COMPUTE: begin
          acc_q <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            Result1 <= acc_next[WIDTH-1:0];
            Result2 <= acc_next[2*WIDTH-1:WIDTH];
            state   <= MC_DONE;
          end
        end
        MC_DONE: state <= MC_IDLE;
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: reference results are queued at issue and compared at completion.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] sb[$];

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference result packed as {Result2, Result1}.
  function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
    if (op == 1'b0) return {32'b0, a} * {32'b0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Count Busy cycles until DONE; optionally drop Start and disturb inputs after acceptance.
  task automatic wait_done(input bit release_start, output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(posedge CLK); #1;
      if (release_start) begin
        Start    = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = ~MCycleOp;
      end
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] exp;
    sb.push_back(model(op, a, b));
    MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    #1;
    wait_done(1'b1, n);
    chk({tag, " busy_cycles"}, 64'(n), 64'd33);
    exp = sb.pop_front();
    chk({tag, " result"}, {Result2, Result1}, exp);
    @(posedge CLK); #1;
    chk({tag, " idle_busy"}, 64'(Busy), 64'd0);
    chk({tag, " held"}, {Result2, Result1}, exp);
  endtask

  initial begin
    int n;
    logic [63:0] exp;
    RESETn = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = '0; Operand2 = '0;

    // Asynchronous reset before any clock edge.
    #3 RESETn = 1'b0;
    #1;
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst results", {Result2, Result1}, 64'd0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK); #1;

    run_op("mul7x6", 1'b0, 32'd7, 32'd6);
    run_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div100_7", 1'b1, 32'd100, 32'd7);
    run_op("divmax_1", 1'b1, 32'hFFFF_FFFF, 32'd1);
    run_op("div_by0", 1'b1, 32'h0000_1234, 32'd0);
    run_op("div_small", 1'b1, 32'd5, 32'd9);
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("rnd%0d", i), 1'(i), $urandom, $urandom_range(1, 32'hFFFF));
    end

    // Start held high: DONE is the only low cycle between the two operations.
    sb.push_back(model(1'b0, 32'd3, 32'd5));
    sb.push_back(model(1'b1, 32'd1000, 32'd33));
    MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5; Start = 1'b1;
    #1;
    wait_done(1'b0, n);
    chk("pair1 busy_cycles", 64'(n), 64'd33);
    chk("pair1 result", {Result2, Result1}, sb.pop_front());
    MCycleOp = 1'b1; Operand1 = 32'd1000; Operand2 = 32'd33;
    @(posedge CLK); #1;
    chk("pair2 restart_busy", 64'(Busy), 64'd1);
    wait_done(1'b1, n);
    chk("pair2 busy_cycles", 64'(n), 64'd33);
    chk("pair2 result", {Result2, Result1}, sb.pop_front());
    @(posedge CLK); #1;

    // Reset in the middle of an operation.
    exp = model(1'b0, 32'hDEAD, 32'hBEEF);
    MCycleOp = 1'b0; Operand1 = 32'hDEAD; Operand2 = 32'hBEEF; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RESETn = 1'b0;
    #1;
    chk("midrst busy", 64'(Busy), 64'd0);
    chk("midrst results", {Result2, Result1}, 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    chk("midrst idle_busy", 64'(Busy), 64'd0);
    run_op("after_rst", 1'b0, 32'hDEAD, 32'hBEEF);
    chk("after_rst model", {Result2, Result1}, exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
